// File: rtl/growing_interp_pkg.sv
// Shared definitions for the growing_interp linear interpolator.
// Optional build macro: GROWING_INTERP_ROUND_EN (round-half-up output instead of truncation).
package growing_interp_pkg;

    localparam int MAX_LOG2 = 7;
    localparam int K_W      = $clog2(MAX_LOG2 + 1);

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        WAIT  = 2'd1,
        EMIT  = 2'd2
    } state_t;

    // Accumulator holds prev<<k plus up to 2^k signed steps, with headroom for the rounding bias.
    function automatic int acc_w(input int n);
        return n + MAX_LOG2 + 2;
    endfunction

endpackage

// File: rtl/growing_interp_acc.sv
// interp_acc: interpolation datapath for growing_interp.
// Holds the scaled accumulator and per-segment step, and produces the scaled-down output sample.
// Optional build macro: GROWING_INTERP_ROUND_EN (round half up before the final shift).
module interp_acc
    import growing_interp_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   prev,
    input  logic [N-1:0]   x,
    input  logic [K_W-1:0] k_load,
    input  logic [K_W-1:0] k_cur,
    output logic [N-1:0]   y_calc
);

    localparam int ACC_W = acc_w(N);

    logic signed [ACC_W-1:0] acc;
    logic signed [N:0]       delta;
    logic signed [ACC_W-1:0] delta_ext;
    logic signed [ACC_W-1:0] prev_scaled;
    logic signed [ACC_W-1:0] acc_biased;

    assign delta_ext   = {{(ACC_W-N-1){delta[N]}}, delta};
    assign prev_scaled = $signed({{(ACC_W-N){1'b0}}, prev} << k_load);

`ifdef GROWING_INTERP_ROUND_EN
    logic signed [ACC_W-1:0] bias;

    // Half of one output LSB at the current scale; zero when there is no fractional part.
    always_comb begin
        bias = '0;
        if (k_cur != '0) begin
            bias = $signed({{(ACC_W-1){1'b0}}, 1'b1} << (k_cur - 1'b1));
        end
    end

    assign acc_biased = acc + bias;
`else
    assign acc_biased = acc;
`endif

    // acc stays between prev<<k and x<<k, so it is never negative and the slice never wraps.
    assign y_calc = N'(acc_biased >>> k_cur);

    // Load starts a new segment (taking priority over the final step of the old one); step walks the ramp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            delta <= '0;
        end else if (load) begin
            acc   <= prev_scaled;
            delta <= $signed({1'b0, x}) - $signed({1'b0, prev});
        end else if (step) begin
            acc <= acc + delta_ext;
        end
    end

endmodule

// File: rtl/growing_interp.sv
// growing_interp: upsamples a decimated stream by 2^k with linear interpolation.
// Owns the handshake, segment phase counter and output registers; interp_acc does the arithmetic.
// Optional build macro: GROWING_INTERP_ROUND_EN (round-half-up output instead of truncation).
module growing_interp
    import growing_interp_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   x,
    input  logic           x_valid,
    output logic           x_ready,
    input  logic [K_W-1:0] N_INTERP_in,
    output logic [N-1:0]   y,
    output logic           y_valid
);

    state_t                state;
    logic [N-1:0]          prev;
    logic [MAX_LOG2-1:0]   phase;
    logic [K_W-1:0]        k_reg;
    logic [MAX_LOG2-1:0]   phase_last;
    logic                  last;
    logic                  xfer;
    logic                  load;
    logic                  step;
    logic [N-1:0]          y_calc;

    assign phase_last = MAX_LOG2'((8'd1 << k_reg) - 8'd1);
    assign last       = (phase == phase_last);
    assign x_ready    = (state != EMIT) || last;
    assign xfer       = x_valid && x_ready;
    assign load       = xfer && (state != PRIME);
    assign step       = (state == EMIT);

    interp_acc #(.N(N)) u_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .prev   (prev),
        .x      (x),
        .k_load (N_INTERP_in),
        .k_cur  (k_reg),
        .y_calc (y_calc)
    );

    // Segment sequencing: prime on the first sample, then emit 2^k outputs per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= PRIME;
            prev    <= '0;
            phase   <= '0;
            k_reg   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            case (state)
                PRIME: begin
                    y_valid <= 1'b0;
                    if (xfer) begin
                        prev  <= x;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    y_valid <= 1'b0;
                    if (xfer) begin
                        k_reg <= N_INTERP_in;
                        phase <= '0;
                        prev  <= x;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    y       <= y_calc;
                    y_valid <= 1'b1;
                    phase   <= phase + 1'b1;
                    if (last) begin
                        if (xfer) begin
                            // Back-to-back segment: no bubble on y_valid.
                            k_reg <= N_INTERP_in;
                            phase <= '0;
                            prev  <= x;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                default: begin
                    state   <= PRIME;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
